octal_scan_controller: RTL and testbench
========================================

// Module: octal_scan_controller
// PURPOSE
//   Time-multiplexes one octal seven-segment decoder across the four board digits (AN3..AN0).
//   Holds a 4-digit octal value and steps through the digits: blank, then drive, for each digit in turn.
//   Accepts new values through a valid/ready handshake and commits them only at a frame boundary, so a frame never mixes old and new digits.
//   Sits between user logic (switch/counter sources) and the board pins CA..CG, DP, AN3..AN0.
// PARAMETERS
//   DRIVE_CYCLES  100000  clk cycles one digit is lit (1 ms at 100 MHz); must be >= 1
//   BLANK_CYCLES  1000    clk cycles all anodes are off before each digit (anti-ghosting); must be >= 1
// PORTS
//   clk        in   1   system clock; every flop is clocked on its rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   upd_valid  in   1   new display contents are offered
//   upd_ready  out  1   controller can accept an update (shadow register empty)
//   upd_value  in   12  four octal digits; [2:0]=digit0 (AN0) .. [11:9]=digit3 (AN3)
//   upd_dp     in   4   decimal point per digit, 1=lit; bit i -> digit i
//   upd_en     in   4   digit enable, 1=shown; 0 keeps that anode off for the whole slot
//   CA..CG     out  1   segment cathodes, active-low
//   DP         out  1   decimal point cathode, active-low
//   AN3..AN0   out  1   digit anodes, active-low
//   frame_done out  1   one-cycle pulse when a 4-digit frame completes
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - State BLANK, digit index 0, cycle counter 0.
//     - Active registers = value 0, dp 0, en 4'b0000 (dark display).
//     - Shadow register empty, so upd_ready=1.
//     - CA..CG=1, DP=1, AN3..AN0=1, frame_done=0.
//   - FSM (2 states):
//     - BLANK: lasts BLANK_CYCLES, then goes to DRIVE with the counter cleared.
//     - DRIVE: lasts DRIVE_CYCLES, then the index increments mod 4 and the FSM returns to BLANK.
//     - Frame length = 4*(BLANK_CYCLES+DRIVE_CYCLES) cycles.
//   - Outputs are registered and lag the FSM/index registers by exactly 1 clk.
//     - BLANK, or DRIVE with en[idx]=0: all anodes 1, CA..CG=1, DP=1.
//     - DRIVE with en[idx]=1: AN[idx]=0, other anodes 1.
//       - CA..CG = decode(value[3*idx+:3]).
//       - DP = ~dp[idx].
//     - At most one anode is ever 0.
//   - Decoder table, octal d -> {CA,CB,CC,CD,CE,CF,CG}:
//     - 0: 0000001
//     - 1: 1001111
//     - 2: 0010010
//     - 3: 0000110
//     - 4: 1001100
//     - 5: 0100100
//     - 6: 0100000
//     - 7: 0001111
//   - Handshake:
//     - Transfer happens on a clk edge with upd_valid && upd_ready; {value,dp,en} is stored in the shadow register.
//     - upd_ready = ~shadow_full.
//     - upd_valid may be held high; no data is consumed while upd_ready=0.
//   - Frame boundary (last DRIVE cycle of digit 3):
//     - index wraps to 0.
//     - frame_done is registered high for the next cycle, aligned with the first output cycle of the new BLANK.
//     - If the shadow register is full, it is copied to the active registers and marked empty.
//   - Simultaneous transfer and frame boundary in the same cycle: the data lands in the shadow register and commits at the next boundary (no bypass).
//   - Reset mid-frame drives all outputs inactive immediately (async); any pending shadow data is discarded.
//   - Counters are sized $clog2(max(DRIVE_CYCLES,BLANK_CYCLES)+1) and must not wrap inside a phase.
// STRUCTURE
//   - Package disp_pkg holds:
//     - typedef enum {ST_BLANK, ST_DRIVE} scan_state_t
//     - NUM_DIGITS=4 and DIGIT_W=3
//     - SEG_OFF=7'h7F
//     - the 8-entry segment table as localparams
//   - Sub-module octal_seg_decoder: purely combinational 3-bit to 7-bit active-low decode, one instance.
//   - The controller contains the FSM, counters, index, shadow/active registers and output flops.
// TESTING (bench uses DRIVE_CYCLES=4, BLANK_CYCLES=2; frame = 24 cycles)
//   1. Reset held 5 cycles, then released with no update -> AN3..AN0=1111 and CA..CG=1111111 for 48 cycles; frame_done pulses at cycles 24 and 48.
//   2. Update value=12'o7654, dp=4'b0000, en=4'b1111 -> transfer takes 1 cycle, upd_ready drops.
//      - After the next frame_done: AN0=0 with segs 1001100 for 4 cycles, then 2 cycles blank, then AN1=0 with segs 0100100.
//      - upd_ready returns to 1 on the commit cycle.
//   3. Second update while shadow is full -> upd_ready=0 and upd_value is ignored until the commit; the held upd_valid then transfers on the first cycle ready=1.
//   4. en=4'b0101, dp=4'b0100 -> AN1 and AN3 never go low; DP=0 only while AN2=0; no cycle with two anodes low.
//   5. Update accepted on the exact frame-boundary cycle -> display keeps old digits for one full frame, new digits appear after the following frame_done.
//   6. rst_n pulsed low mid-DRIVE of digit 2 -> all outputs go to 1 without waiting for clk; after release, the scan restarts at digit 0 in BLANK with a dark display.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the octal seven-segment scan controller.
// Segment patterns are {CA,CB,CC,CD,CE,CF,CG}, active-low.
package disp_pkg;

   typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 3;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;

endpackage

// File: rtl/octal_seg_decoder.sv
// Combinational octal digit to active-low seven-segment pattern.
module octal_seg_decoder
   import disp_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_digit,
   output logic [6:0]         o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      unique case (i_digit)
         3'd0: o_seg = SEG_0;
         3'd1: o_seg = SEG_1;
         3'd2: o_seg = SEG_2;
         3'd3: o_seg = SEG_3;
         3'd4: o_seg = SEG_4;
         3'd5: o_seg = SEG_5;
         3'd6: o_seg = SEG_6;
         3'd7: o_seg = SEG_7;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/octal_scan_controller.sv
// Scans four octal digits onto a shared seven-segment bus with blanking between digits.
// Updates are buffered in a shadow register and committed only at a frame boundary.
module octal_scan_controller
   import disp_pkg::*;
#(
   parameter int unsigned DRIVE_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_upd_valid,
   output logic        o_upd_ready,
   input  logic [11:0] i_upd_value,
   input  logic [3:0]  i_upd_dp,
   input  logic [3:0]  i_upd_en,
   output logic        o_ca,
   output logic        o_cb,
   output logic        o_cc,
   output logic        o_cd,
   output logic        o_ce,
   output logic        o_cf,
   output logic        o_cg,
   output logic        o_dp,
   output logic        o_an3,
   output logic        o_an2,
   output logic        o_an1,
   output logic        o_an0,
   output logic        o_frame_done
);

   localparam int unsigned MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES
                                                                       : BLANK_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned VAL_W = NUM_DIGITS * DIGIT_W;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]         r_idx, w_idx_nxt;
   logic                     w_boundary;

   logic                     r_sh_full;
   logic [VAL_W-1:0]         r_sh_value, r_act_value;
   logic [NUM_DIGITS-1:0]    r_sh_dp, r_sh_en, r_act_dp, r_act_en;
   logic                     w_xfer;

   logic                     w_lit;
   logic [DIGIT_W-1:0]       w_digit;
   logic [6:0]               w_dec_seg, w_seg_nxt, r_seg;
   logic                     w_dp_nxt, r_dp;
   logic [NUM_DIGITS-1:0]    w_an_nxt, r_an;
   logic                     r_boundary, r_frame_done;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_boundary  = 1'b0;
      unique case (r_state)
         ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = ST_DRIVE;
               w_cnt_nxt   = '0;
            end
         end
         ST_DRIVE: begin
            if (r_cnt == DRIVE_LAST) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = r_idx + 1'b1;
               w_boundary  = (r_idx == IDX_LAST);
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // A transfer needs an empty shadow and a commit needs a full one, so they never collide.
   assign w_xfer      = i_upd_valid & ~r_sh_full;
   assign o_upd_ready = ~r_sh_full;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh_full   <= 1'b0;
         r_sh_value  <= '0;
         r_sh_dp     <= '0;
         r_sh_en     <= '0;
         r_act_value <= '0;
         r_act_dp    <= '0;
         r_act_en    <= '0;
      end else if (w_xfer) begin
         r_sh_full  <= 1'b1;
         r_sh_value <= i_upd_value;
         r_sh_dp    <= i_upd_dp;
         r_sh_en    <= i_upd_en;
      end else if (w_boundary && r_sh_full) begin
         r_sh_full   <= 1'b0;
         r_act_value <= r_sh_value;
         r_act_dp    <= r_sh_dp;
         r_act_en    <= r_sh_en;
      end
   end

   assign w_digit = r_act_value[DIGIT_W*r_idx +: DIGIT_W];

   octal_seg_decoder u_dec (
      .i_digit (w_digit),
      .o_seg   (w_dec_seg)
   );

   always_comb begin
      w_lit     = (r_state == ST_DRIVE) && r_act_en[r_idx];
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
      w_an_nxt  = '1;
      if (w_lit) begin
         w_seg_nxt = w_dec_seg;
         w_dp_nxt  = ~r_act_dp[r_idx];
         w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
      end
   end

   // frame_done is delayed twice so it lines up with the first blank output cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seg        <= SEG_OFF;
         r_dp         <= 1'b1;
         r_an         <= '1;
         r_boundary   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_dp         <= w_dp_nxt;
         r_an         <= w_an_nxt;
         r_boundary   <= w_boundary;
         r_frame_done <= r_boundary;
      end
   end

   assign {o_ca, o_cb, o_cc, o_cd, o_ce, o_cf, o_cg} = r_seg;
   assign o_dp                                       = r_dp;
   assign {o_an3, o_an2, o_an1, o_an0}               = r_an;
   assign o_frame_done                               = r_frame_done;

endmodule

// File: tb/tb_octal_scan_controller.sv
// Directed bench for octal_scan_controller with 2 blank + 4 drive cycles per digit.
module tb_octal_scan_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [11:0] upd_value = '0;
   logic [3:0]  upd_dp = '0;
   logic [3:0]  upd_en = '0;
   logic        ca, cb, cc, cd, ce, cf, cg, dp;
   logic        an3, an2, an1, an0;
   logic        frame_done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          cyc = 0;

   logic [6:0]  seg_tbl [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
   logic [11:0] f_val [8];
   logic [3:0]  f_dp  [8];
   logic [3:0]  f_en  [8];

   always #5 clk = ~clk;

   octal_scan_controller #(
      .DRIVE_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_upd_valid  (upd_valid),
      .o_upd_ready  (upd_ready),
      .i_upd_value  (upd_value),
      .i_upd_dp     (upd_dp),
      .i_upd_en     (upd_en),
      .o_ca         (ca),
      .o_cb         (cb),
      .o_cc         (cc),
      .o_cd         (cd),
      .o_ce         (ce),
      .o_cf         (cf),
      .o_cg         (cg),
      .o_dp         (dp),
      .o_an3        (an3),
      .o_an2        (an2),
      .o_an1        (an1),
      .o_an0        (an0),
      .o_frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Cycle 1 is the first output cycle after reset release; a frame spans 24 cycles and
   // each digit slot is 2 blank output cycles followed by 4 lit ones.
   task automatic check_cycle(input logic [11:0] val, input logic [3:0] dpm,
                              input logic [3:0] en, input logic exp_ready);
      int          p, slot, ph;
      logic        lit;
      logic [11:0] sh;
      logic [2:0]  d;
      logic [3:0]  exp_an;
      logic [6:0]  exp_seg;
      logic        exp_dp;
      p       = (cyc - 1) % 24;
      slot    = p / 6;
      ph      = p % 6;
      lit     = (ph >= 2) && en[slot];
      sh      = val >> (3 * slot);
      d       = sh[2:0];
      exp_an  = lit ? ~(4'b0001 << slot) : 4'hF;
      exp_seg = lit ? seg_tbl[d] : 7'h7F;
      exp_dp  = lit ? ~dpm[slot] : 1'b1;
      check_eq("anodes", 32'({an3, an2, an1, an0}), 32'(exp_an));
      check_eq("segments", 32'({ca, cb, cc, cd, ce, cf, cg}), 32'(exp_seg));
      check_eq("dp", 32'(dp), 32'(exp_dp));
      check_eq("frame_done", 32'(frame_done), 32'((p == 0) && (cyc > 1)));
      check_eq("upd_ready", 32'(upd_ready), 32'(exp_ready));
   endtask

   function automatic logic exp_ready_main(input int c);
      if (c <= 49)       return 1'b1;
      else if (c <= 71)  return 1'b0;
      else if (c == 72)  return 1'b1;
      else if (c <= 95)  return 1'b0;
      else if (c <= 119) return 1'b1;
      else if (c <= 143) return 1'b0;
      else if (c <= 170) return 1'b1;
      else               return 1'b0;
   endfunction

   initial begin
      for (int f = 0; f < 8; f++) begin
         f_val[f] = '0;
         f_dp[f]  = '0;
         f_en[f]  = '0;
      end
      f_val[3] = 12'o7654; f_dp[3] = 4'b0000; f_en[3] = 4'b1111;
      f_val[4] = 12'o0123; f_dp[4] = 4'b0100; f_en[4] = 4'b0101;
      f_val[5] = 12'o0123; f_dp[5] = 4'b0100; f_en[5] = 4'b0101;
      f_val[6] = 12'o5432; f_dp[6] = 4'b1000; f_en[6] = 4'b1111;
      f_val[7] = 12'o5432; f_dp[7] = 4'b1000; f_en[7] = 4'b1111;

      repeat (5) @(negedge clk);
      check_eq("rst_anodes", 32'({an3, an2, an1, an0}), 32'h0000000F);
      check_eq("rst_segments", 32'({ca, cb, cc, cd, ce, cf, cg}), 32'h0000007F);
      check_eq("rst_dp", 32'(dp), 32'd1);
      check_eq("rst_frame_done", 32'(frame_done), 32'd0);
      check_eq("rst_upd_ready", 32'(upd_ready), 32'd1);
      rst_n = 1'b1;

      for (int c = 1; c <= 184; c++) begin
         @(negedge clk);
         cyc = c;
         check_cycle(f_val[(c - 1) / 24], f_dp[(c - 1) / 24], f_en[(c - 1) / 24],
                     exp_ready_main(c));
         case (c)
            49:  begin upd_valid = 1'b1; upd_value = 12'o7654; upd_dp = 4'b0000;
                       upd_en = 4'b1111; end
            50:  begin upd_value = 12'o0123; upd_dp = 4'b0100; upd_en = 4'b0101; end
            73:  upd_valid = 1'b0;
            119: begin upd_valid = 1'b1; upd_value = 12'o5432; upd_dp = 4'b1000;
                       upd_en = 4'b1111; end
            120: upd_valid = 1'b0;
            170: begin upd_valid = 1'b1; upd_value = 12'o7777; upd_dp = 4'b1111;
                       upd_en = 4'b1111; end
            171: upd_valid = 1'b0;
            default: ;
         endcase
      end

      // Digit 2 is lit here; reset lands between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_anodes", 32'({an3, an2, an1, an0}), 32'h0000000F);
      check_eq("async_segments", 32'({ca, cb, cc, cd, ce, cf, cg}), 32'h0000007F);
      check_eq("async_dp", 32'(dp), 32'd1);
      check_eq("async_frame_done", 32'(frame_done), 32'd0);
      check_eq("async_upd_ready", 32'(upd_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int c = 1; c <= 49; c++) begin
         @(negedge clk);
         cyc = c;
         check_cycle(12'o0000, 4'b0000, 4'b0000, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
